// File: rtl/i2s_receiver_if.sv
// I2S receive bundle: serial lines in, parallel stereo samples and status out.
interface i2s_receiver_if #(
    parameter int SAMPLE_WIDTH = 16
);
    logic                    i2s_bclk;
    logic                    i2s_lrclk;
    logic                    i2s_data;
    logic [SAMPLE_WIDTH-1:0] sample_l;
    logic [SAMPLE_WIDTH-1:0] sample_r;
    logic                    sample_valid;
    logic                    frame_err;
    logic                    locked;

    modport master (
        output i2s_bclk, i2s_lrclk, i2s_data,
        input  sample_l, sample_r, sample_valid, frame_err, locked
    );

    modport slave (
        input  i2s_bclk, i2s_lrclk, i2s_data,
        output sample_l, sample_r, sample_valid, frame_err, locked
    );
endinterface

// File: rtl/i2s_receiver.sv
// Philips I2S stereo deserialiser; all I2S lines oversampled on mclk.
module i2s_receiver #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SYNC_STAGES  = 2
) (
    input logic          mclk,
    input logic          reset,
    i2s_receiver_if.slave bus
);
    localparam int CW = $clog2(SAMPLE_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(SAMPLE_WIDTH - 1);

    typedef enum logic [1:0] {
        SEEK,
        SHIFT,
        PAD
    } state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  bclk_sync;
    logic [SYNC_STAGES-1:0]  lr_sync;
    logic [SYNC_STAGES-1:0]  data_sync;
    logic                    bclk_prev;
    logic                    lr_last;
    logic                    lr_seen;
    logic                    chan;
    logic                    left_ok;
    logic [CW-1:0]           bit_cnt;
    logic [SAMPLE_WIDTH-1:0] shift_reg;
    logic [SAMPLE_WIDTH-1:0] hold_l;
    logic [SAMPLE_WIDTH-1:0] out_l;
    logic [SAMPLE_WIDTH-1:0] out_r;
    logic                    out_valid;
    logic                    out_err;
    logic                    out_locked;

    logic                    bclk_s;
    logic                    lr_s;
    logic                    data_s;
    logic                    rise;
    logic                    boundary;
    logic [SAMPLE_WIDTH-1:0] shift_word;

    always_comb begin
        bclk_s     = bclk_sync[SYNC_STAGES-1];
        lr_s       = lr_sync[SYNC_STAGES-1];
        data_s     = data_sync[SYNC_STAGES-1];
        rise       = bclk_s & ~bclk_prev;
        // lr_last is meaningless until one rise has been seen after reset,
        // so the first event can never fake a slot boundary.
        boundary   = rise & lr_seen & (lr_s != lr_last);
        shift_word = {shift_reg[SAMPLE_WIDTH-2:0], data_s};
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            bclk_sync <= '0;
            lr_sync   <= '0;
            data_sync <= '0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bus.i2s_bclk};
            lr_sync   <= {lr_sync[SYNC_STAGES-2:0], bus.i2s_lrclk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], bus.i2s_data};
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state      <= SEEK;
            bclk_prev  <= 1'b0;
            lr_last    <= 1'b0;
            lr_seen    <= 1'b0;
            chan       <= 1'b0;
            left_ok    <= 1'b0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            hold_l     <= '0;
            out_l      <= '0;
            out_r      <= '0;
            out_valid  <= 1'b0;
            out_err    <= 1'b0;
            out_locked <= 1'b0;
        end else begin
            bclk_prev <= bclk_s;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            if (rise) begin
                lr_last <= lr_s;
                lr_seen <= 1'b1;
            end
            if (boundary) begin
                bit_cnt <= '0;
                chan    <= lr_s;
                state   <= SHIFT;
                if (state == SEEK) out_locked <= 1'b1;
                if (state == SHIFT) begin
                    out_err <= 1'b1;
                    left_ok <= 1'b0;
                end
                if (!lr_s) left_ok <= 1'b0;
            end else if (rise && state == SHIFT) begin
                shift_reg <= shift_word;
                bit_cnt   <= bit_cnt + 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    state <= PAD;
                    if (!chan) begin
                        hold_l  <= shift_word;
                        left_ok <= 1'b1;
                    end else if (left_ok) begin
                        out_l     <= hold_l;
                        out_r     <= shift_word;
                        out_valid <= 1'b1;
                        left_ok   <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.sample_l     = out_l;
    assign bus.sample_r     = out_r;
    assign bus.sample_valid = out_valid;
    assign bus.frame_err    = out_err;
    assign bus.locked       = out_locked;
endmodule

// File: tb/tb_i2s_receiver.sv
// Randomised I2S stream against a slot-level pairing model.
module tb_i2s_receiver;
    localparam int W         = 16;
    localparam int HALF_BCLK = 40;

    logic mclk = 1'b0;
    logic reset;
    always #5 mclk = ~mclk;

    i2s_receiver_if #(.SAMPLE_WIDTH(W)) bus ();

    i2s_receiver #(
        .SAMPLE_WIDTH(W),
        .SYNC_STAGES (2)
    ) dut (
        .mclk (mclk),
        .reset(reset),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Slot-level model: a slot is the run of rise events sharing one lrclk value,
    // and nbits counts the data rises after the word-select change.
    bit             m_locked;
    bit             m_pending;
    bit             m_prev_counted;
    int             m_prev_lr;
    int             m_prev_bits;
    logic [W-1:0]   m_left;
    int             exp_err;
    int             exp_valid;
    logic [31:0]    exp_q[$];
    logic [31:0]    last_pair;
    int             valid_cycles;
    int             err_cycles;

    task automatic model_reset();
        m_locked       = 1'b0;
        m_pending      = 1'b0;
        m_prev_counted = 1'b0;
        m_prev_lr      = -1;
        m_prev_bits    = 0;
        last_pair      = '0;
    endtask

    task automatic drive_cycle(input bit lr, input bit d);
        bus.i2s_bclk  = 1'b0;
        bus.i2s_lrclk = lr;
        bus.i2s_data  = d;
        #HALF_BCLK;
        bus.i2s_bclk  = 1'b1;
        #HALF_BCLK;
    endtask

    // pad_kind: 0 = zeros, 1 = ones, otherwise random
    task automatic send_slot(input bit lr, input int nbits, input logic [W-1:0] word, input int pad_kind);
        bit counted;
        bit b;
        counted = 1'b0;
        if (m_prev_lr >= 0 && int'(lr) != m_prev_lr) begin
            if (m_prev_counted && m_prev_bits < W) begin
                exp_err++;
                m_pending = 1'b0;
            end
            if (!lr) m_pending = 1'b0;
            m_locked = 1'b1;
            counted  = 1'b1;
        end
        m_prev_lr      = int'(lr);
        m_prev_counted = counted;
        m_prev_bits    = nbits;
        if (counted && nbits >= W) begin
            if (!lr) begin
                m_left    = word;
                m_pending = 1'b1;
            end else if (m_pending) begin
                exp_q.push_back({m_left, word});
                exp_valid++;
                m_pending = 1'b0;
            end
        end
        drive_cycle(lr, 1'($urandom_range(1)));
        for (int i = 0; i < nbits; i++) begin
            if (i < W) b = word[W-1-i];
            else if (pad_kind == 0) b = 1'b0;
            else if (pad_kind == 1) b = 1'b1;
            else b = 1'($urandom_range(1));
            drive_cycle(lr, b);
        end
        check_eq("locked", {31'd0, bus.locked}, {31'd0, m_locked});
    endtask

    task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input int nbits, input int pad_kind);
        send_slot(1'b0, nbits, l, pad_kind);
        send_slot(1'b1, nbits, r, pad_kind);
    endtask

    always @(negedge mclk) begin
        if (!reset) begin
            if (bus.frame_err) err_cycles++;
            if (bus.sample_valid) begin
                valid_cycles++;
                check_eq("valid_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    last_pair = exp_q.pop_front();
                    check_eq("sample_pair", {bus.sample_l, bus.sample_r}, last_pair);
                end
            end else begin
                check_eq("sample_hold", {bus.sample_l, bus.sample_r}, last_pair);
            end
        end
    end

    initial begin
        exp_err      = 0;
        exp_valid    = 0;
        valid_cycles = 0;
        err_cycles   = 0;
        model_reset();
        reset         = 1'b1;
        bus.i2s_bclk  = 1'b0;
        bus.i2s_lrclk = 1'b1;
        bus.i2s_data  = 1'b0;
        repeat (3) @(negedge mclk);
        check_eq("rst_sample_l", {16'd0, bus.sample_l}, 32'd0);
        check_eq("rst_sample_r", {16'd0, bus.sample_r}, 32'd0);
        check_eq("rst_valid", {31'd0, bus.sample_valid}, 32'd0);
        check_eq("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
        check_eq("rst_locked", {31'd0, bus.locked}, 32'd0);

        // Stream already 8 bits into a right slot when reset releases
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'($urandom_range(1)));
        reset = 1'b0;
        send_slot(1'b1, 12, W'($urandom), 2);

        send_frame(16'hA5C3, 16'h1234, 31, 1);
        send_frame(16'h8000, 16'h7FFF, 31, 2);
        send_frame(16'hFFFF, 16'h0001, 24, 0);

        // Short left slot: error at the right boundary, orphan right word
        send_slot(1'b0, 10, W'($urandom), 2);
        send_slot(1'b1, 31, W'($urandom), 2);
        send_frame(16'h2468, 16'hACE1, 31, 2);
        check_eq("short_err_count", 32'(err_cycles), 32'(exp_err));

        send_frame(16'h0F0F, 16'hF0F0, 16, 2);
        send_frame(16'h0F0F, 16'hF0F0, 16, 2);

        for (int f = 0; f < 20; f++) begin
            int nl;
            int nr;
            nl = W + $urandom_range(15);
            nr = W + $urandom_range(15);
            if ($urandom_range(5) == 0) nl = 1 + $urandom_range(W - 2);
            if ($urandom_range(7) == 0) nr = 1 + $urandom_range(W - 2);
            send_slot(1'b0, nl, W'($urandom), 2);
            send_slot(1'b1, nr, W'($urandom), 2);
        end
        send_frame(W'($urandom), W'($urandom), 20, 2);

        // Reset mid-right-slot after a captured left word
        send_slot(1'b0, 16, 16'h1111, 2);
        send_slot(1'b1, 8, W'($urandom), 2);
        check_eq("no_pairs_before_reset", 32'(exp_q.size()), 32'd0);
        @(negedge mclk);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_sample_l", {16'd0, bus.sample_l}, 32'd0);
        check_eq("mid_rst_sample_r", {16'd0, bus.sample_r}, 32'd0);
        check_eq("mid_rst_locked", {31'd0, bus.locked}, 32'd0);
        check_eq("mid_rst_valid", {31'd0, bus.sample_valid}, 32'd0);
        model_reset();
        exp_q.delete();
        repeat (2) @(negedge mclk);
        reset = 1'b0;
        send_slot(1'b1, 10, W'($urandom), 2);
        send_frame(W'($urandom), W'($urandom), 31, 2);
        send_frame(W'($urandom), W'($urandom), 16, 2);

        repeat (20) @(negedge mclk);
        check_eq("pairs_outstanding", 32'(exp_q.size()), 32'd0);
        check_eq("valid_cycles", 32'(valid_cycles), 32'(exp_valid));
        check_eq("frame_err_cycles", 32'(err_cycles), 32'(exp_err));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
